// File: rtl/decoder_scan_n_pkg.sv
// Shared types and constants for the scanning one-hot decoder.
// Holds mode input encodings and the two-state FSM encoding.
// Imported by decoder_scan_n and scan_prescaler.
package decoder_scan_n_pkg;

  // Values of the mode input
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Operating state; the register lags mode by one cycle so the first
  // SCAN cycle after DIRECT (or reset) can be recognised as the entry cycle.
  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

endpackage

// File: rtl/decoder_scan_n_scan_prescaler.sv
// Slot prescaler: counts 0..DIV-1 while enabled, wraps on terminal count.
// Latency: tc_o is combinational from the count register and en_i.
// Backpressure: none; clr_i has priority over en_i, count holds when en_i=0.
module scan_prescaler
  import decoder_scan_n_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int DIV_W = $clog2(DIV) + 1;

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             last;

  assign last = (cnt_q == DIV_W'(DIV - 1));
  assign tc_o = en_i && last;

  // Next count: clear, wrap on the last slot cycle, or step by one
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with DIRECT and SCAN modes.
// Latency: 1 clk from inputs to d/idx/tick; all outputs registered.
// Backpressure: none; en=0 blanks d and freezes the scan position.
// Optional feature: define DEC_MASK_EN to add the per-output blank mask port.
module decoder_scan_n
  import decoder_scan_n_pkg::*;
#(
  parameter  int SEL_W = 3,
  parameter  int DIV   = 4,
  localparam int OUT_W = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
`ifdef DEC_MASK_EN
  input  logic [OUT_W-1:0] mask,
`endif
  output logic [OUT_W-1:0] d,
  output logic [SEL_W-1:0] idx,
  output logic             tick
);

  state_e           state_q;
  logic [OUT_W-1:0] d_q;
  logic [OUT_W-1:0] d_d;
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_d;
  logic             tick_q;
  logic             tick_d;
  logic [OUT_W-1:0] blank;
  logic             scan_run;
  logic             scan_clr;
  logic             slot_end;

`ifdef DEC_MASK_EN
  assign blank = mask;
`else
  assign blank = '0;
`endif

  // The prescaler only runs in steady SCAN; DIRECT and the entry cycle clear it
  assign scan_clr = (mode == MODE_DIRECT) || (state_q == ST_DIRECT);
  assign scan_run = (mode == MODE_SCAN) && (state_q == ST_SCAN) && en;

  scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr_i (scan_clr),
    .en_i  (scan_run),
    .tc_o  (slot_end)
  );

  // Next decoded index, one-hot pattern and advance pulse
  always_comb begin
    d_d    = '0;
    idx_d  = idx_q;
    tick_d = 1'b0;
    if (mode == MODE_DIRECT) begin
      idx_d = sel;
      d_d   = en ? (OUT_W'(1) << sel) : '0;
    end else if (state_q == ST_DIRECT) begin
      // First SCAN cycle always restarts from slot 0
      idx_d = '0;
      d_d   = en ? OUT_W'(1) : '0;
    end else if (en) begin
      if (slot_end) begin
        idx_d  = idx_q + SEL_W'(1);
        tick_d = 1'b1;
      end
      d_d = OUT_W'(1) << idx_d;
    end
  end

  // FSM and registered outputs; blanking is applied after decode so idx
  // and tick are unaffected by the mask
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_DIRECT;
      d_q     <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
      d_q     <= d_d & ~blank;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
    end
  end

  assign d    = d_q;
  assign idx  = idx_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Self-checking bench for decoder_scan_n (SEL_W=3) with DIV=4 and DIV=1 copies
// driven by identical stimulus and checked against a slot/phase model.
module tb_decoder_scan_n;

  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [2:0] sel;
  logic [7:0] mask;
  logic [7:0] d0, d1;
  logic [2:0] idx0, idx1;
  logic       tick0, tick1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decoder_scan_n #(.SEL_W(3), .DIV(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
`ifdef DEC_MASK_EN
    .mask(mask),
`endif
    .d(d0), .idx(idx0), .tick(tick0)
  );

  decoder_scan_n #(.SEL_W(3), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
`ifdef DEC_MASK_EN
    .mask(mask),
`endif
    .d(d1), .idx(idx1), .tick(tick1)
  );

  // Reference model: scanning position kept as slot number and phase
  // (cycles spent in the current slot), both as plain integers.
  typedef struct {
    bit         scan;
    int         ph;
    int         slot;
    logic [7:0] d;
    logic [2:0] idx;
    bit         tick;
  } mdl_t;

  mdl_t m[2];
  int   divs[2] = '{4, 1};

  function automatic mdl_t mstep(mdl_t s, int div, bit r, bit e, bit mo,
                                 int sl, logic [7:0] mk);
    mdl_t n = s;
    n.tick = 0;
    if (r) begin
      n.scan = 0; n.ph = 0; n.slot = 0; n.d = 8'h00; n.idx = 3'd0;
      return n;
    end
    if (!mo) begin
      n.scan = 0; n.ph = 0; n.slot = sl;
      n.d = e ? 8'(1 << sl) : 8'h00;
    end else if (!s.scan) begin
      n.scan = 1; n.ph = 0; n.slot = 0;
      n.d = e ? 8'h01 : 8'h00;
    end else if (e) begin
      if (s.ph + 1 == div) begin
        n.ph = 0; n.slot = (s.slot + 1) % 8; n.tick = 1;
      end else begin
        n.ph = s.ph + 1;
      end
      n.d = 8'(1 << n.slot);
    end else begin
      n.d = 8'h00;
    end
    n.d   = n.d & ~mk;
    n.idx = 3'(n.slot);
    return n;
  endfunction

  function automatic logic [7:0] cur_mask();
`ifdef DEC_MASK_EN
    return mask;
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge,
  // then settle before anything is compared.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      m[k] = mstep(m[k], divs[k], rst, en, mode, int'(sel), cur_mask());
    #1;
  endtask

  task automatic cmp_model(string tag);
    chk({tag, " d div4"},    32'(d0),    32'(m[0].d));
    chk({tag, " idx div4"},  32'(idx0),  32'(m[0].idx));
    chk({tag, " tick div4"}, 32'(tick0), 32'(m[0].tick));
    chk({tag, " d div1"},    32'(d1),    32'(m[1].d));
    chk({tag, " idx div1"},  32'(idx1),  32'(m[1].idx));
    chk({tag, " tick div1"}, 32'(tick1), 32'(m[1].tick));
    chk({tag, " onehot div4"}, 32'($countones(d0) <= 1), 32'(1));
    chk({tag, " onehot div1"}, 32'($countones(d1) <= 1), 32'(1));
  endtask

  typedef struct {
    bit         rst, en, mode;
    logic [2:0] sel;
    logic [7:0] ed;
    logic [2:0] ei;
    bit         et;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int n, ticks, first, held;
    bit wrapped;
    logic [7:0] prev_d;

    // Directed DIRECT-mode vectors: reset, full decode, enable gating
    tbl[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 3'd7, 8'h00, 3'd0, 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[2 + i] = '{1'b0, 1'b1, 1'b0, 3'(i), 8'(1 << i), 3'(i), 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 3'd5, 8'h00, 3'd5, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 3'd5, 8'h20, 3'd5, 1'b0};

    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 3'd0; mask = 8'h00;
    for (int k = 0; k < 2; k++) m[k] = '{0, 0, 0, 8'h00, 3'd0, 0};
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; mode = tbl[i].mode; sel = tbl[i].sel;
      step();
      chk($sformatf("tbl%0d d", i),    32'(d0),    32'(tbl[i].ed));
      chk($sformatf("tbl%0d idx", i),  32'(idx0),  32'(tbl[i].ei));
      chk($sformatf("tbl%0d tick", i), 32'(tick0), 32'(tbl[i].et));
      cmp_model("tbl");
    end

    // Full scan sweep: entry, then 36 edges -> 9 advances and a wrap
    mode = 1'b1; en = 1'b1; sel = 3'd6;
    step();
    chk("scan entry d", 32'(d0), 32'h01);
    chk("scan entry idx", 32'(idx0), 32'd0);
    cmp_model("entry");
    ticks = 0; wrapped = 0;
    for (int i = 0; i < 36; i++) begin
      prev_d = d0;
      step();
      cmp_model("sweep");
      if (tick0) ticks++;
      if (prev_d == 8'h80 && d0 == 8'h01) wrapped = 1;
      sel = 3'($urandom);
    end
    chk("sweep tick count", 32'(ticks), 32'd9);
    chk("sweep wrap seen", 32'(wrapped), 32'd1);

    // Freeze at slot 3, one cycle into the slot
    n = 0;
    while (!(m[0].slot == 3 && m[0].ph == 1) && n < 100) begin
      step(); cmp_model("seek3"); n++;
    end
    chk("seek slot3 bound", 32'(n < 100), 32'd1);
    held = m[0].ph;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold d", 32'(d0), 32'h00);
      chk("hold idx", 32'(idx0), 32'd3);
      chk("hold tick", 32'(tick0), 32'd0);
      cmp_model("hold");
    end
    en = 1'b1;
    step();
    chk("resume d", 32'(d0), 32'h08);
    cmp_model("resume");
    n = 0;
    do begin step(); cmp_model("resume run"); n++; end while (!tick0 && n < 10);
    chk("resume remaining cycles", 32'(n), 32'(4 - 1 - held));
    chk("resume advance d", 32'(d0), 32'h10);

    // Reset mid-slot at slot 6 while mode stays SCAN
    n = 0;
    while (!(m[0].slot == 6 && m[0].ph == 2) && n < 100) begin
      step(); cmp_model("seek6"); n++;
    end
    chk("seek slot6 bound", 32'(n < 100), 32'd1);
    rst = 1'b1;
    step();
    chk("rst d", 32'(d0), 32'h00);
    chk("rst idx", 32'(idx0), 32'd0);
    chk("rst tick", 32'(tick0), 32'd0);
    cmp_model("rst");
    rst = 1'b0;
    step();
    chk("post-rst d", 32'(d0), 32'h01);
    chk("post-rst div1 d", 32'(d1), 32'h01);
    cmp_model("post-rst");
    first = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      cmp_model("post-rst run");
      chk("div1 tick", 32'(tick1), 32'd1);
      chk("div1 idx", 32'(idx1), 32'(k % 8));
      if (tick0 && first < 0) first = k;
    end
    chk("post-rst first tick", 32'(first), 32'd4);

`ifdef DEC_MASK_EN
    // Blanked slots keep their timing; DIRECT honours the mask too
    mask = 8'h0A; mode = 1'b0; step(); cmp_model("mask pre");
    mode = 1'b1; step(); cmp_model("mask entry");
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      cmp_model("mask scan");
      if (tick0) ticks++;
      if (idx0 == 3'd1 || idx0 == 3'd3) chk("masked slot d", 32'(d0), 32'h00);
    end
    chk("mask tick count", 32'(ticks), 32'd10);
    mode = 1'b0; sel = 3'd1; step();
    chk("mask direct d", 32'(d0), 32'h00);
    chk("mask direct idx", 32'(idx0), 32'd1);
    mask = 8'h00;
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 39) == 0);
      en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      sel  = 3'($urandom);
`ifdef DEC_MASK_EN
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
`endif
      step();
      cmp_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
